// File: rtl/bot_app_if.sv
// Application-side register window onto the Rojobot BOTSIM: snapshots the status registers,
// raises an interrupt for each update and holds the motor/config registers that drive BOTSIM.
module bot_app_if #(
    parameter logic [7:0] RD_BASE     = 8'h00,
    parameter logic [7:0] MOTCTL_PORT = 8'h09,
    parameter logic [7:0] BOTCFG_PORT = 8'h0A,
    parameter logic [7:0] BOTCFG_RST  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd_sysregs,
    input  logic [7:0] LocX_in,
    input  logic [7:0] LocY_in,
    input  logic [7:0] Sensors_in,
    input  logic [7:0] BotInfo_in,
    input  logic [7:0] LMDist_in,
    input  logic [7:0] RMDist_in,
    output logic [7:0] MotCtl_out,
    output logic [7:0] BotConfig_out,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    typedef enum logic {StIdle, StPend} state_e;

    state_e     state_q;
    logic       upd_q;
    logic [7:0] locx_q, locy_q, sensors_q, botinfo_q, lmdist_q, rmdist_q;
    logic [7:0] upd_cnt_q;
    logic [7:0] ovr_cnt_q;

    logic       upd_edge;
    logic       pending;
    logic       overrun;
    logic       ovr_clr;
    logic [7:0] rd_off;
    logic [7:0] rd_data;

    always_comb begin
        upd_edge = upd_sysregs & ~upd_q;
        pending  = (state_q == StPend);
        // An ack arriving with the new edge consumes the previous update, so no overrun.
        overrun  = pending & upd_edge & ~interrupt_ack;
        ovr_clr  = read_strobe & (port_id == RD_BASE + 8'd7);
        rd_off   = port_id - RD_BASE;
    end

    always_comb begin
        rd_data = 8'h00;
        if (port_id == MOTCTL_PORT + 8'h10) begin
            rd_data = upd_cnt_q;
        end else if (rd_off < 8'd8) begin
            unique case (rd_off[2:0])
                3'd0: rd_data = locx_q;
                3'd1: rd_data = locy_q;
                3'd2: rd_data = sensors_q;
                3'd3: rd_data = botinfo_q;
                3'd4: rd_data = lmdist_q;
                3'd5: rd_data = rmdist_q;
                3'd6: rd_data = {7'b0, pending};
                3'd7: rd_data = ovr_cnt_q;
                default: rd_data = 8'h00;
            endcase
        end
    end

    assign interrupt = pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            upd_q         <= 1'b0;
            locx_q        <= 8'h00;
            locy_q        <= 8'h00;
            sensors_q     <= 8'h00;
            botinfo_q     <= 8'h00;
            lmdist_q      <= 8'h00;
            rmdist_q      <= 8'h00;
            upd_cnt_q     <= 8'h00;
            ovr_cnt_q     <= 8'h00;
            in_port       <= 8'h00;
            MotCtl_out    <= 8'h00;
            BotConfig_out <= BOTCFG_RST;
        end else begin
            upd_q   <= upd_sysregs;
            in_port <= rd_data;

            if (upd_edge) begin
                locx_q    <= LocX_in;
                locy_q    <= LocY_in;
                sensors_q <= Sensors_in;
                botinfo_q <= BotInfo_in;
                lmdist_q  <= LMDist_in;
                rmdist_q  <= RMDist_in;
                upd_cnt_q <= upd_cnt_q + 8'd1;
            end

            unique case (state_q)
                StIdle: if (upd_edge) state_q <= StPend;
                StPend: if (interrupt_ack && !upd_edge) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (ovr_clr) begin
                ovr_cnt_q <= overrun ? 8'h01 : 8'h00;
            end else if (overrun && ovr_cnt_q != 8'hFF) begin
                ovr_cnt_q <= ovr_cnt_q + 8'd1;
            end

            if (write_strobe && port_id == MOTCTL_PORT) MotCtl_out <= out_port;
            if (write_strobe && port_id == BOTCFG_PORT) BotConfig_out <= out_port;
        end
    end

endmodule
